// File: rtl/summer_pkg.sv
// Shared types and helpers for the moving-window summer: sum width,
// output mode decode and the wrap/saturate truncation.
package summer_pkg;

  typedef enum logic {
    SUM_WRAP = 1'b0,
    SUM_SAT  = 1'b1
  } summer_mode_e;

  typedef struct packed {
    logic        ovf;
    logic [31:0] data;
  } trunc_t;

  // Internal sum needs enough headroom for DEPTH full-scale samples.
  function automatic int unsigned sum_width(input int unsigned data_w,
                                            input int unsigned depth);
    return data_w + $clog2(depth);
  endfunction

  function automatic trunc_t sat_trunc(input logic [31:0]     sum,
                                       input int unsigned     data_w,
                                       input summer_mode_e    mode);
    logic [31:0] max_val;
    trunc_t      r;
    max_val = (32'd1 << data_w) - 32'd1;
    r.ovf   = (sum > max_val);
    r.data  = (r.ovf && mode == SUM_SAT) ? max_val : (sum & max_val);
    return r;
  endfunction

endpackage

// File: rtl/window_summer_hist_buf.sv
// DEPTH-entry circular history of accepted samples; the slot under the write
// pointer is the oldest sample and is presented combinationally.
module summer_hist_buf
  import summer_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] oldest
);

  localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (push) begin
      mem[wr_ptr] <= din;
      wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Empty slots hold 0, so an unfilled window subtracts nothing.
  always_comb oldest = mem[wr_ptr];

endmodule

// File: rtl/window_summer.sv
// Streaming moving-window adder with ready/valid on both sides, a running
// sum, fill tracking, overflow flag and optional saturation.
module window_summer
  import summer_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned SAT_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic              out_full
);

  localparam int unsigned      SUM_W    = sum_width(DATA_W, DEPTH);
  localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);
  localparam summer_mode_e     MODE     = (SAT_EN != 0) ? SUM_SAT : SUM_WRAP;

  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_next;
  logic [CNT_W-1:0]  fill_cnt;
  logic [CNT_W-1:0]  fill_next;
  logic              full_next;
  logic              accept;
  logic [DATA_W-1:0] oldest;
  trunc_t            tr;
  logic              unused_trunc_hi;

  summer_hist_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_hist (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .push   (accept),
    .din    (in_data),
    .oldest (oldest)
  );

  always_comb begin
    in_ready  = !clear && (!out_valid || out_ready);
    accept    = in_valid && in_ready;
    // oldest is already part of sum, so the subtraction cannot underflow.
    sum_next  = sum + SUM_W'(in_data) - SUM_W'(oldest);
    full_next = (fill_cnt >= CNT_W'(DEPTH - 1));
    fill_next = full_next ? FILL_MAX : fill_cnt + 1'b1;
    tr        = sat_trunc(32'(sum_next), DATA_W, MODE);
    unused_trunc_hi = ^tr.data[31:DATA_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum       <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_full  <= 1'b0;
    end else if (clear) begin
      sum       <= '0;
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_full  <= 1'b0;
    end else if (accept) begin
      sum       <= sum_next;
      fill_cnt  <= fill_next;
      out_valid <= 1'b1;
      out_data  <= tr.data[DATA_W-1:0];
      out_ovf   <= tr.ovf;
      out_full  <= full_next;
    end else if (!out_valid || out_ready) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_full  <= 1'b0;
    end
  end

endmodule
